dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Data-memory stage directly downstream of the address decoder in the RISC datapath.
//  Consumes the decoder's CS / iWE / iAddress plus the raw ALU address, and owns the word-addressed data RAM.
//  Performs loads (2-cycle, stalls the pipeline) and stores (1-cycle).
//  Flags accesses outside the data window and returns load data to write-back.
// PARAMETERS
//  DATA_W   32    data word width
//  DEPTH    1024  RAM words; matches the 0x780..0xB7F window, one word per iAddress value
//  ADDR_W   10    RAM index width, clog2(DEPTH)
// PORTS
//  clk        in   1       single system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req        in   1       memory op valid this cycle (load or store); held by pipeline while stall=1
//  CS         in   1       decoder chip select: address inside data window
//  iWE        in   1       decoder-gated write enable (1=store, 0=load)
//  iAddress   in   32      decoder offset (inputResult - window base)
//  inputResult in  32      raw ALU address, for fault capture only
//  wdata      in   DATA_W  store data
//  rdata      out  DATA_W  load data to write-back
//  stall      out  1       freeze PC/pipeline registers
//  op_done    out  1       one-cycle pulse: op completed (store, load data valid, or fault)
//  err        out  1       sticky out-of-window fault flag
//  err_addr   out  32      inputResult of the first fault since last clear
//  err_clr    in   1       synchronous clear of err / err_addr
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; rdata=0, stall=0, op_done=0, err=0, err_addr=0.
//   - RAM contents not reset.
//  Request decoding, evaluated in IDLE
//   - valid access : req & CS & (iAddress < DEPTH)
//   - fault        : req & !(CS & iAddress < DEPTH)
//   - no req       : no action; outputs hold except op_done=0.
//  FSM states: IDLE, RD_WAIT
//   IDLE, valid store (iWE=1)
//    - RAM[iAddress[ADDR_W-1:0]] <= wdata at this edge.
//    - stall=0; op_done=1 registered, i.e. pulses the following cycle.
//    - Stay in IDLE. Back-to-back stores: one per cycle.
//   IDLE, valid load (iWE=0)
//    - RAM read issued at this edge; stall=1 combinationally this cycle; -> RD_WAIT.
//   RD_WAIT
//    - RAM dout valid.
//    - rdata <= dout at the edge ending RD_WAIT; stall=0 combinationally; op_done=1 next cycle.
//    - -> IDLE. req ignored in RD_WAIT (same op still held).
//    - Load latency: 2 cycles; stall high exactly 1 cycle.
//   IDLE, fault
//    - No RAM access; rdata <= 0; op_done pulses; no stall.
//    - If err=0: err<=1, err_addr<=inputResult. If err=1: err_addr unchanged (first fault kept).
//  Other rules
//   - rdata holds its last load value until the next load or fault.
//   - err_clr and a new fault in the same cycle: the fault wins (err=1, err_addr=new address).
//   - err_clr with no fault: err<=0, err_addr<=0.
//   - rst_n asserted in RD_WAIT: immediate IDLE, stall drops asynchronously, load is lost, no op_done.
//   - iWE=1 with CS=0 never writes RAM (the decoder already zeroes iWE; fault path enforced here anyway).
//   - Upper iAddress bits [31:ADDR_W] nonzero with CS=1 -> fault.
// STRUCTURE
//  - Shared include dmem_defs.vh: DATA_W, DEPTH, ADDR_W, state encodings (IDLE=1'b0, RD_WAIT=1'b1),
//    data window base/limit constants shared with the decoder.
//  - Sub-module dmem_ram: single-port synchronous RAM, 1-cycle registered read, write-first ignored
//    (no read/write in the same cycle by construction).
//  - Top: FSM, stall/op_done logic, fault capture.
// TESTING
//  - Store then load: store wdata=0xDEADBEEF to inputResult=0x780 (iAddress=0), then load the same address
//    -> stall=1 for 1 cycle, rdata=0xDEADBEEF, op_done pulses once per op.
//  - Upper edge: store 0x12345678 to 0xB7F (iAddress=0x3FF), load back -> 0x12345678;
//    RAM word 0 untouched.
//  - Fault: req, CS=0, inputResult=0x00000B80 -> err=1, err_addr=0xB80, rdata=0, no stall, RAM unchanged;
//    a second fault at 0x10 keeps err_addr=0xB80.
//  - Clear vs fault: err_clr=1 with a fault at 0x20 in the same cycle -> err=1, err_addr=0x20;
//    err_clr alone next -> err=0, err_addr=0.
//  - Back-to-back: 3 stores (one per cycle, no stall), then 2 loads
//    -> 2 stall cycles total, correct data in order.
//  - Reset mid-load: rst_n=0 during RD_WAIT -> stall=0 immediately, state IDLE, rdata=0, no op_done;
//    RAM data survives reset and reloads correctly.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access stage.
// Holds the RAM geometry, the data window limits shared with the address
// decoder, the FSM state type and a helper that qualifies an access.
package dmem_access_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  // Data window in ALU address space, one RAM word per address value.
  localparam logic [31:0] WIN_BASE  = 32'h0000_0780;
  localparam logic [31:0] WIN_LIMIT = 32'h0000_0B7F;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // An access reaches the RAM only if the decoder selected the window and
  // the offset lands inside the RAM. Any upper offset bit set means fault.
  function automatic logic addr_ok(input logic cs, input logic [31:0] iaddr);
    return cs && (iaddr < 32'(DEPTH));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline <-> data-memory bus.
// Handshake: the pipeline raises req with CS/iWE/iAddress/inputResult/wdata
// and holds all of them stable while stall=1. A store or fault is taken at
// the first rising edge with req=1; a load stalls for its first cycle, then
// completes at the edge ending RD_WAIT. op_done pulses the cycle after any
// op completes. err/err_addr report the first out-of-window access until
// err_clr.
// master : pipeline side (drives request), slave : dmem_access_ctrl.
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;

  logic              req;
  logic              CS;
  logic              iWE;
  logic [31:0]       iAddress;
  logic [31:0]       inputResult;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              op_done;
  logic              err;
  logic [31:0]       err_addr;
  logic              err_clr;

  modport master (
    output req, CS, iWE, iAddress, inputResult, wdata, err_clr,
    input  rdata, stall, op_done, err, err_addr
  );

  modport slave (
    input  req, CS, iWE, iAddress, inputResult, wdata, err_clr,
    output rdata, stall, op_done, err, err_addr
  );

endinterface

// File: rtl/dmem_access_ctrl_ram.sv
// Single-port synchronous data RAM.
// Ports: clk, we (write din to addr), re (register mem[addr] into dout),
// addr, din, dout. dout is valid the cycle after re and holds otherwise.
// Read and write never happen in the same cycle, so no collision handling.
// Contents are deliberately not reset.
module dmem_access_ctrl_ram
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout      <= mem[addr];
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller.
// Ports: clk, rst_n (async active-low), bus (slave side of
// dmem_access_ctrl_if), dbg_state (current FSM state).
// Stores complete in one cycle, loads take two with a one-cycle stall,
// out-of-window accesses are turned into faults captured in err/err_addr.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave bus,
  output state_t            dbg_state
);

  state_t            state, state_nx;
  logic              valid;
  logic              do_store, do_load, do_fault;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] rdata_q;
  logic              op_done_q;
  logic              err_q;
  logic [31:0]       err_addr_q;

  assign valid = addr_ok(bus.CS, bus.iAddress);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Requests are only decoded in IDLE; in RD_WAIT the same load is still
  // being held by the stalled pipeline and must not be re-issued.
  always_comb begin
    state_nx = state;
    do_store = 1'b0;
    do_load  = 1'b0;
    do_fault = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (!valid) begin
            do_fault = 1'b1;
          end else if (bus.iWE) begin
            do_store = 1'b1;
          end else begin
            do_load  = 1'b1;
            state_nx = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  dmem_access_ctrl_ram #(.DW(DATA_W), .AW(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (do_store),
    .re   (do_load),
    .addr (bus.iAddress[ADDR_W-1:0]),
    .din  (bus.wdata),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      op_done_q  <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      op_done_q <= do_store | do_fault | (state == ST_RD_WAIT);
      if (state == ST_RD_WAIT) rdata_q <= ram_dout;
      else if (do_fault)       rdata_q <= '0;
      // A fault beats a simultaneous clear; otherwise the first fault
      // address is kept until software clears it.
      if (do_fault) begin
        err_q <= 1'b1;
        if (!err_q || bus.err_clr) err_addr_q <= bus.inputResult;
      end else if (bus.err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

  // Gated with rst_n so the pipeline is released the moment reset asserts.
  assign bus.stall    = do_load & rst_n;
  assign bus.rdata    = rdata_q;
  assign bus.op_done  = op_done_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;

  // ---------------- reference model ----------------
  logic [31:0] mem_m [int];
  int          wr_list[$];
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  logic [31:0] m_rdata = '0;
  logic [DATA_W-1:0] exp_q[$];

  always @(negedge clk) if (bus.stall === 1'b1) stall_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drive one op at a negedge with DUT in IDLE; returns at the negedge where
  // op_done must be high, after checking the completed op against the model.
  task automatic issue(input logic we, input logic cs, input logic [31:0] ia,
                       input logic [31:0] ir, input logic [31:0] wd,
                       input logic clr);
    logic valid;
    logic is_load;
    valid   = cs && (ia < 32'(DEPTH));
    is_load = valid && !we;
    bus.req = 1'b1; bus.CS = cs; bus.iWE = we; bus.iAddress = ia;
    bus.inputResult = ir; bus.wdata = wd; bus.err_clr = clr;
    #1;
    n_checks++;
    if (bus.stall !== is_load) begin
      n_errors++; $display("FAIL stall_issue: got %b expected %b (ir=%h)", bus.stall, is_load, ir);
    end
    if (!valid) begin
      m_rdata = '0;
      if (!m_err || clr) m_err_addr = ir;
      m_err = 1'b1;
    end else begin
      if (we) begin mem_m[int'(ia)] = wd; wr_list.push_back(int'(ia)); end
      else exp_q.push_back(mem_m[int'(ia)]);
      if (clr) begin m_err = 1'b0; m_err_addr = '0; end
    end
    @(posedge clk);
    if (is_load) begin
      @(negedge clk);
      bus.err_clr = 1'b0;
      n_checks++;
      if (dbg_state !== ST_RD_WAIT || bus.stall !== 1'b0 || bus.op_done !== 1'b0) begin
        n_errors++;
        $display("FAIL rd_wait: got state=%0d stall=%b op_done=%b expected state=1 stall=0 op_done=0",
                 dbg_state, bus.stall, bus.op_done);
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (is_load) m_rdata = exp_q.pop_front();
    n_checks++;
    if (bus.op_done !== 1'b1) begin
      n_errors++; $display("FAIL op_done: got %b expected 1 (ir=%h)", bus.op_done, ir);
    end
    n_checks++;
    if (bus.rdata !== m_rdata) begin
      n_errors++; $display("FAIL rdata: got %h expected %h (ir=%h)", bus.rdata, m_rdata, ir);
    end
    n_checks++;
    if (bus.err !== m_err || bus.err_addr !== m_err_addr) begin
      n_errors++;
      $display("FAIL err: got err=%b addr=%h expected err=%b addr=%h", bus.err, bus.err_addr, m_err, m_err_addr);
    end
  endtask

  // Decoder model: window hit gives CS=1 and offset from the window base.
  task automatic op_dec(input logic we, input logic [31:0] ir, input logic [31:0] wd);
    logic cs;
    cs = (ir >= WIN_BASE) && (ir <= WIN_LIMIT);
    issue(we & cs, cs, ir - WIN_BASE, ir, wd, 1'b0);
  endtask

  task automatic idle(input logic clr);
    bus.req = 1'b0; bus.err_clr = clr;
    if (clr) begin m_err = 1'b0; m_err_addr = '0; end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.op_done !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== m_rdata ||
        bus.err !== m_err || bus.err_addr !== m_err_addr) begin
      n_errors++;
      $display("FAIL idle: got op_done=%b stall=%b rdata=%h err=%b addr=%h expected 0 0 %h %b %h",
               bus.op_done, bus.stall, bus.rdata, bus.err, bus.err_addr, m_rdata, m_err, m_err_addr);
    end
    bus.err_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req = 1'b0; bus.CS = 1'b0; bus.iWE = 1'b0; bus.iAddress = '0;
    bus.inputResult = '0; bus.wdata = '0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rdata !== '0 || bus.stall !== 1'b0 || bus.op_done !== 1'b0 ||
        bus.err !== 1'b0 || bus.err_addr !== '0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset: got rdata=%h stall=%b op_done=%b err=%b addr=%h state=%0d expected all zero",
               bus.rdata, bus.stall, bus.op_done, bus.err, bus.err_addr, dbg_state);
    end
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_store_load();
    stall_cnt = 0;
    op_dec(1'b1, 32'h780, 32'hDEADBEEF);
    idle(1'b0);
    op_dec(1'b0, 32'h780, 32'h0);
    idle(1'b0);
    n_checks++;
    if (stall_cnt != 1) begin
      n_errors++; $display("FAIL stall_cycles_single: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_upper_edge();
    op_dec(1'b1, 32'hB7F, 32'h12345678);
    op_dec(1'b0, 32'hB7F, 32'h0);
    op_dec(1'b0, 32'h780, 32'h0);
    idle(1'b0);
  endtask

  task automatic test_fault();
    issue(1'b1, 1'b0, 32'h0, 32'hB80, 32'hBAD0BAD0, 1'b0);
    issue(1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h400, 32'hB80, 32'h11111111, 1'b0);
    issue(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0780, 32'h22222222, 1'b0);
    op_dec(1'b0, 32'h780, 32'h0);
    idle(1'b0);
  endtask

  task automatic test_clear_vs_fault();
    issue(1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    stall_cnt = 0;
    op_dec(1'b1, 32'h790, 32'hA1A1A1A1);
    op_dec(1'b1, 32'h791, 32'hB2B2B2B2);
    op_dec(1'b1, 32'h792, 32'hC3C3C3C3);
    op_dec(1'b0, 32'h792, 32'h0);
    op_dec(1'b0, 32'h790, 32'h0);
    idle(1'b0);
    n_checks++;
    if (stall_cnt != 2) begin
      n_errors++; $display("FAIL stall_cycles_b2b: got %0d expected 2", stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        op_dec(1'b1, WIN_BASE + $urandom_range(0, DEPTH - 1), $urandom);
      end else if (sel < 7) begin
        op_dec(1'b0, WIN_BASE + 32'(wr_list[$urandom_range(0, wr_list.size() - 1)]), 32'h0);
      end else if (sel < 9) begin
        logic [31:0] ir;
        ir = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h77F)) : (WIN_LIMIT + 1 + $urandom_range(0, 4096));
        issue(1'($urandom_range(0, 1)), 1'b0, 32'h0, ir, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        idle(1'($urandom_range(0, 1)));
      end
    end
    idle(1'b0);
  endtask

  task automatic test_reset_mid_load();
    issue(1'b0, 1'b0, 32'h0, 32'h30, 32'h0, 1'b0);
    bus.req = 1'b1; bus.CS = 1'b1; bus.iWE = 1'b0; bus.iAddress = 32'h0;
    bus.inputResult = 32'h780; bus.err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_RD_WAIT) begin
      n_errors++; $display("FAIL mid_load_state: got %0d expected 1", dbg_state);
    end
    bus.req = 1'b0;
    rst_n = 1'b0;
    #1;
    m_err = 1'b0; m_err_addr = '0; m_rdata = '0;
    n_checks++;
    if (bus.stall !== 1'b0 || dbg_state !== ST_IDLE || bus.rdata !== '0 ||
        bus.err !== 1'b0 || bus.err_addr !== '0) begin
      n_errors++;
      $display("FAIL mid_load_reset: got stall=%b state=%0d rdata=%h err=%b addr=%h expected 0 0 0 0 0",
               bus.stall, dbg_state, bus.rdata, bus.err, bus.err_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    op_dec(1'b0, 32'h780, 32'h0);
    op_dec(1'b0, 32'hB7F, 32'h0);
    idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_upper_edge();
    test_fault();
    test_clear_vs_fault();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
